// File: rtl/fdtd_axi_pkg.sv
// rtl/fdtd_axi_pkg.sv - shared AXI4 encodings for the FDTD memory ports
package fdtd_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // 4-byte transfers: every access is one full 32-bit word
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    // SLVERR and DECERR are the two failing responses (MSB set)
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/fdtd_mem_word_rd.sv
// rtl/fdtd_mem_word_rd.sv - single-word AXI4 read master (sticky error flag under FDTD_MEM_RD_ERR_EN)
module fdtd_mem_word_rd
    import fdtd_axi_pkg::*;
#(
    parameter int AXI4_ADDR_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH = 32,
    parameter int AXI4_ID_WIDTH   = 16,
    parameter int AXI4_USER_WIDTH = 10
) (
    input  logic                         ACLK,
    input  logic                         ARESET,

    output logic [AXI4_ID_WIDTH-1:0]     ARID_o,
    output logic [AXI4_ADDR_WIDTH-1:0]   ARADDR_o,
    output logic [7:0]                   ARLEN_o,
    output logic [2:0]                   ARSIZE_o,
    output logic [1:0]                   ARBURST_o,
    output logic                         ARLOCK_o,
    output logic [3:0]                   ARCACHE_o,
    output logic [2:0]                   ARPROT_o,
    output logic [3:0]                   ARREGION_o,
    output logic [AXI4_USER_WIDTH-1:0]   ARUSER_o,
    output logic [3:0]                   ARQOS_o,
    output logic                         ARVALID_o,
    input  logic                         ARREADY_i,

    input  logic [AXI4_ID_WIDTH-1:0]     RID_i,
    input  logic [AXI4_DATA_WIDTH-1:0]   RDATA_i,
    input  logic [1:0]                   RRESP_i,
    input  logic                         RLAST_i,
    input  logic [AXI4_USER_WIDTH-1:0]   RUSER_i,
    input  logic                         RVALID_i,
    output logic                         RREADY_o,

    input  logic                         rd_req_i,
    input  logic [AXI4_ADDR_WIDTH-3:0]   rd_word_addr_i,
    output logic                         rd_gnt_o,
    output logic [AXI4_DATA_WIDTH-1:0]   rd_rdata_o,
    output logic                         rd_err_o,
    input  logic                         rd_err_clr_i
);

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_AR   = 2'd1,
        RS_R    = 2'd2,
        RS_DONE = 2'd3
    } rd_state_e;

    rd_state_e                  state_q, state_d;
    logic                       arvalid_q, arvalid_d;
    logic                       rready_q, rready_d;
    logic [AXI4_ADDR_WIDTH-3:0] addr_q, addr_d;
    logic [AXI4_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // a beat is taken whenever the slave presents data while we wait in RS_R
    logic beat_fire;
    assign beat_fire = (state_q == RS_R) && RVALID_i;

    // state and handshake registers; reset abandons any in-flight transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= RS_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
        end
    end

    // next-state logic: AR handshake, then R beats until RLAST, then grant
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        case (state_q)
            RS_IDLE: begin
                if (rd_req_i) begin
                    addr_d    = rd_word_addr_i;
                    arvalid_d = 1'b1;
                    state_d   = RS_AR;
                end
            end
            RS_AR: begin
                if (ARREADY_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RS_R;
                end
            end
            RS_R: begin
                // a misbehaving slave may send extra beats; keep the last one
                if (RVALID_i) begin
                    rdata_d = RDATA_i;
                    if (RLAST_i) begin
                        rready_d = 1'b0;
                        state_d  = RS_DONE;
                    end
                end
            end
            RS_DONE: begin
                state_d = RS_IDLE;
            end
            default: begin
                state_d   = RS_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

`ifdef FDTD_MEM_RD_ERR_EN
    logic err_q;

    // sticky error: a failing beat wins over a same-cycle clear
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_q <= 1'b0;
        end else if (beat_fire && resp_is_err(RRESP_i)) begin
            err_q <= 1'b1;
        end else if (rd_err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign rd_err_o = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{RID_i, RUSER_i};
`else
    assign rd_err_o = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{RID_i, RUSER_i, RRESP_i, rd_err_clr_i, beat_fire};
`endif

    assign ARID_o     = '0;
    assign ARADDR_o   = {addr_q, 2'b00};
    assign ARLEN_o    = 8'd0;
    assign ARSIZE_o   = SIZE_WORD;
    assign ARBURST_o  = BURST_INCR;
    assign ARLOCK_o   = 1'b0;
    assign ARCACHE_o  = 4'd0;
    assign ARPROT_o   = 3'd0;
    assign ARREGION_o = 4'd0;
    assign ARUSER_o   = '0;
    assign ARQOS_o    = 4'd0;
    assign ARVALID_o  = arvalid_q;
    assign RREADY_o   = rready_q;

    assign rd_gnt_o   = (state_q == RS_DONE);
    assign rd_rdata_o = rdata_q;

endmodule

// File: tb/tb_fdtd_mem_word_rd.sv
// tb/tb_fdtd_mem_word_rd.sv - scoreboard bench for fdtd_mem_word_rd
module tb_fdtd_mem_word_rd;

`ifdef FDTD_MEM_RD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] ARID_o;
    logic [31:0] ARADDR_o;
    logic [7:0]  ARLEN_o;
    logic [2:0]  ARSIZE_o;
    logic [1:0]  ARBURST_o;
    logic        ARLOCK_o;
    logic [3:0]  ARCACHE_o;
    logic [2:0]  ARPROT_o;
    logic [3:0]  ARREGION_o;
    logic [9:0]  ARUSER_o;
    logic [3:0]  ARQOS_o;
    logic        ARVALID_o;
    logic        ARREADY_i;
    logic [15:0] RID_i;
    logic [31:0] RDATA_i;
    logic [1:0]  RRESP_i;
    logic        RLAST_i;
    logic [9:0]  RUSER_i;
    logic        RVALID_i;
    logic        RREADY_o;
    logic        rd_req_i;
    logic [29:0] rd_word_addr_i;
    logic        rd_gnt_o;
    logic [31:0] rd_rdata_o;
    logic        rd_err_o;
    logic        rd_err_clr_i;

    fdtd_mem_word_rd dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID_o(ARID_o), .ARADDR_o(ARADDR_o), .ARLEN_o(ARLEN_o), .ARSIZE_o(ARSIZE_o),
        .ARBURST_o(ARBURST_o), .ARLOCK_o(ARLOCK_o), .ARCACHE_o(ARCACHE_o), .ARPROT_o(ARPROT_o),
        .ARREGION_o(ARREGION_o), .ARUSER_o(ARUSER_o), .ARQOS_o(ARQOS_o),
        .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
        .RID_i(RID_i), .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RLAST_i(RLAST_i),
        .RUSER_i(RUSER_i), .RVALID_i(RVALID_i), .RREADY_o(RREADY_o),
        .rd_req_i(rd_req_i), .rd_word_addr_i(rd_word_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_rdata_o(rd_rdata_o), .rd_err_o(rd_err_o), .rd_err_clr_i(rd_err_clr_i)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: every grant must match the oldest outstanding expectation
    always @(negedge ACLK) begin
        if (!ARESET && rd_gnt_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("gnt_rdata", {32'd0, rd_rdata_o}, {32'd0, e.data});
                check("gnt_err", {63'd0, rd_err_o}, {63'd0, e.err});
            end
        end
    end

    // one word read against a scripted slave
    task automatic do_read(input string name, input logic [29:0] wa, input logic [31:0] d,
                           input int ar_dly, input int r_dly, input logic [1:0] resp,
                           input bit two, input logic exp_err);
        int   cyc, ar_cnt, rr_cnt, r_seen, beat, lat;
        bit   got, addr_ok;
        exp_t e;
        e.data = d;
        e.err  = exp_err;
        exp_q.push_back(e);
        rd_word_addr_i = wa;
        rd_req_i = 1'b1;
        @(posedge ACLK); #1;
        cyc = 1; ar_cnt = 0; rr_cnt = 0; r_seen = 0; beat = 0; lat = 0;
        got = 1'b0; addr_ok = 1'b1;
        while (!got && cyc < 64) begin
            if (ARVALID_o) begin
                ar_cnt++;
                if (ARADDR_o !== {wa, 2'b00}) addr_ok = 1'b0;
            end
            ARREADY_i = ARVALID_o && (ar_cnt > ar_dly);
            RVALID_i = 1'b0;
            RLAST_i  = 1'b0;
            if (RREADY_o) begin
                rr_cnt++;
                r_seen++;
                if (r_seen > r_dly) begin
                    RVALID_i = 1'b1;
                    RDATA_i  = (two && beat == 0) ? 32'h1 : d;
                    RLAST_i  = !two || (beat == 1);
                    RRESP_i  = resp;
                    beat++;
                end
            end
            if (rd_gnt_o) begin
                got = 1'b1;
                lat = cyc;
                rd_req_i = 1'b0;
            end else begin
                @(posedge ACLK); #1;
                cyc++;
            end
        end
        ARREADY_i = 1'b0;
        RVALID_i  = 1'b0;
        RLAST_i   = 1'b0;
        RRESP_i   = 2'b00;
        rd_req_i  = 1'b0;
        check({name, "_granted"}, {63'd0, got}, 64'd1);
        check({name, "_latency"}, lat, 3 + ar_dly + r_dly + (two ? 1 : 0));
        check({name, "_arvalid_cycles"}, ar_cnt, ar_dly + 1);
        check({name, "_araddr_stable"}, {63'd0, addr_ok}, 64'd1);
        check({name, "_rready_cycles"}, rr_cnt, r_dly + 1 + (two ? 1 : 0));
        @(posedge ACLK); #1;
        check({name, "_gnt_one_cycle"}, {63'd0, rd_gnt_o}, 64'd0);
        check({name, "_rdata_held"}, {32'd0, rd_rdata_o}, {32'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        ARESET = 1'b1;
        ARREADY_i = 1'b0; RVALID_i = 1'b0; RLAST_i = 1'b0; RRESP_i = 2'b00;
        RDATA_i = 32'hFFFF_FFFF; RID_i = 16'h1234; RUSER_i = 10'h155;
        rd_req_i = 1'b0; rd_word_addr_i = 30'h3FFF_FFFF; rd_err_clr_i = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_arvalid", {63'd0, ARVALID_o}, 64'd0);
        check("rst_rready", {63'd0, RREADY_o}, 64'd0);
        check("rst_gnt", {63'd0, rd_gnt_o}, 64'd0);
        check("rst_rdata", {32'd0, rd_rdata_o}, 64'd0);
        check("rst_err", {63'd0, rd_err_o}, 64'd0);
        check("rst_araddr", {32'd0, ARADDR_o}, 64'd0);
        check("ar_consts", {ARID_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARLOCK_o, ARCACHE_o,
                            ARPROT_o, ARREGION_o, ARUSER_o, ARQOS_o},
              {16'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 10'd0, 4'd0});
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        do_read("base",    30'h0000_0400, 32'hDEAD_BEEF, 0, 0, 2'b00, 1'b0, 1'b0);
        check("base_araddr_val", {32'd0, ARADDR_o}, 64'h0000_1000);
        do_read("ar_dly",  30'h0ABC_DEF1, 32'hCAFE_F00D, 4, 0, 2'b00, 1'b0, 1'b0);
        do_read("r_dly",   30'h0000_0007, 32'h1234_5678, 0, 3, 2'b00, 1'b0, 1'b0);
        do_read("two_beat", 30'h0000_0010, 32'h0000_0002, 0, 0, 2'b00, 1'b1, 1'b0);

        do_read("slverr",  30'h0000_0020, 32'hA5A5_0001, 1, 1, 2'b10, 1'b0, ERR_EN);
        do_read("sticky",  30'h0000_0021, 32'hA5A5_0002, 0, 0, 2'b00, 1'b0, ERR_EN);
        check("err_before_clr", {63'd0, rd_err_o}, {63'd0, ERR_EN});
        rd_err_clr_i = 1'b1;
        @(posedge ACLK); #1;
        rd_err_clr_i = 1'b0;
        check("err_after_clr", {63'd0, rd_err_o}, 64'd0);
        do_read("decerr",  30'h0000_0022, 32'hA5A5_0003, 0, 2, 2'b11, 1'b0, ERR_EN);
        rd_err_clr_i = 1'b1;
        @(posedge ACLK); #1;
        rd_err_clr_i = 1'b0;

        // reset while waiting for read data
        rd_word_addr_i = 30'h0000_0100;
        rd_req_i = 1'b1;
        w = 0;
        @(posedge ACLK); #1;
        while (!RREADY_o && w < 20) begin
            ARREADY_i = ARVALID_o;
            @(posedge ACLK); #1;
            w++;
        end
        ARREADY_i = 1'b0;
        check("rst_mid_reached_r", {63'd0, RREADY_o}, 64'd1);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("rst_mid_rready", {63'd0, RREADY_o}, 64'd0);
        check("rst_mid_arvalid", {63'd0, ARVALID_o}, 64'd0);
        check("rst_mid_gnt", {63'd0, rd_gnt_o}, 64'd0);
        ARESET = 1'b0;
        rd_req_i = 1'b0;
        repeat (2) begin
            @(posedge ACLK); #1;
            check("rst_mid_no_gnt", {63'd0, rd_gnt_o}, 64'd0);
        end
        do_read("post_rst", 30'h0000_0200, 32'h0BAD_F00D, 0, 0, 2'b00, 1'b0, 1'b0);

        repeat (2) @(posedge ACLK);
        #1;
        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
